hazard_bubble_stage: RTL
========================

// Module: hazard_bubble_stage
// PURPOSE
//  Registered ID/EX control-word stage with hazard handling for the MIPS pipeline.
//  Zeroes the control word (bubble) on load-use risk or flush, and holds PC and IF/ID for multi-cycle stalls.
//  Latches halt and supports debug single-step gating.
//  Sits between the control unit / risk unit and the ID/EX datapath latch.
// PARAMETERS
//  CTRL_W           24  width of packed control word (reg_dst_rd..jalR), bit order owned by the control unit
//  LOAD_USE_CYCLES  1   bubbles inserted per load-use risk, >=1
//  PERF_W           16  width of bubble performance counter
// PORTS
//  i_clk           in   1               pipeline clock, rising edge
//  i_rst_n         in   1               asynchronous reset, active-low
//  i_step_en       in   1               debug unit advance enable; 0 = every register holds
//  i_valid         in   1               ID stage holds a real instruction
//  i_ctrl          in   CTRL_W          control word from control unit
//  i_halt          in   1               ID instruction is HALT
//  i_risk          in   1               load-use hazard from risk unit
//  i_flush         in   1               taken branch/jump: squash ID instruction
//  o_ctrl          out  CTRL_W          registered control word to EX (all-zero on bubble)
//  o_valid         out  1               EX slot holds a real instruction
//  o_bubble        out  1               EX slot is an inserted bubble (risk or flush)
//  o_stall_pc      out  1               hold PC and IF/ID this cycle (combinational)
//  o_halt          out  1               pipeline halted, sticky until reset
//  o_perf_bubbles  out  PERF_W          risk-bubble count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, i_rst_n=0): o_ctrl=0, o_valid=0, o_bubble=0, o_halt=0, state=RUN, cnt=0, perf=0.
//  Registers update only on rising i_clk with i_step_en=1. With i_step_en=0, all state and outputs hold.
//  Latency: ID->EX is 1 cycle.
//  FSM states: RUN, STALL, HALTED.
//  RUN, with priority flush > risk > pass:
//   - i_flush: o_ctrl<=0, o_valid<=0, o_bubble<=1, stay RUN.
//   - i_risk&i_valid: o_ctrl<=0, o_valid<=0, o_bubble<=1, cnt<=LOAD_USE_CYCLES-1.
//     Next state is STALL if LOAD_USE_CYCLES>1, else RUN.
//   - otherwise: o_ctrl<=i_ctrl, o_valid<=i_valid, o_bubble<=0.
//     If i_valid&i_halt, go to HALTED and set o_halt<=1 on the same edge.
//  STALL: each step inserts a bubble and cnt<=cnt-1. At cnt==1 the next state is RUN.
//   - i_flush in STALL: bubble, cnt<=0, go to RUN.
//  HALTED: o_ctrl=0, o_valid=0, o_bubble=0, o_halt=1. Only reset exits; i_risk and i_flush are ignored.
//  o_stall_pc = (RUN & i_risk & i_valid & ~i_flush) | STALL | HALTED.
//  Simultaneous i_risk & i_flush: flush wins, no stall, no perf count.
//  i_risk with i_valid=0 is ignored.
//  Reset mid-STALL aborts the stall immediately (o_stall_pc=0 while in reset).
//  The halt instruction itself is passed to EX (o_valid=1) so earlier instructions drain.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   - o_perf_bubbles increments by 1 per risk-caused bubble (RUN entry and each STALL cycle).
//   - Saturates at all-ones; flush bubbles are not counted.
//  HAZARD_PERF_CNT_EN undefined: counter is not built; o_perf_bubbles is tied to 0.
// TESTING
//  1. Reset, step_en=1, valid=1, ctrl=24'hABCDEF, no risk
//     -> o_ctrl=24'hABCDEF, o_valid=1 one cycle later; o_stall_pc=0.
//  2. LOAD_USE_CYCLES=1, risk=1 for 1 cycle
//     -> o_stall_pc=1 that cycle; next o_ctrl=0, o_bubble=1; then normal pass resumes.
//  3. LOAD_USE_CYCLES=3, risk pulse
//     -> 3 consecutive bubbles, o_stall_pc=1 for 3 cycles;
//        perf=3 with HAZARD_PERF_CNT_EN, 0 without.
//  4. risk=1 and flush=1 in the same cycle
//     -> one bubble, o_stall_pc=0, perf unchanged.
//     Then flush during STALL -> state returns to RUN next cycle.
//  5. valid=1, halt=1 -> o_halt=1 and o_valid=1 next cycle, then o_ctrl=0 forever.
//     Risk/flush ignored; only i_rst_n=0 clears o_halt.
//  6. step_en=0 for 4 cycles mid-STALL -> all outputs frozen.
//     Assert i_rst_n=0 asynchronously -> outputs zero immediately, state RUN.

Source files
------------

// File: rtl/hazard_bubble_stage.sv
// ID/EX control-word stage: inserts bubbles on load-use risk or flush, stalls PC/IF-ID, latches halt.
// Optional macro HAZARD_PERF_CNT_EN builds a saturating counter of risk-caused bubbles.
module hazard_bubble_stage #(
  parameter int CTRL_W          = 24,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int PERF_W          = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_step_en,
  input  logic              i_valid,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_halt,
  input  logic              i_risk,
  input  logic              i_flush,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_valid,
  output logic              o_bubble,
  output logic              o_stall_pc,
  output logic              o_halt,
  output logic [PERF_W-1:0] o_perf_bubbles
);

  // cnt only needs to hold LOAD_USE_CYCLES-1, the bubbles still owed after the RUN entry
  localparam int CNT_W = (LOAD_USE_CYCLES > 1) ? $clog2(LOAD_USE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_USE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_STALL  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic              bubble_q, bubble_d;
  logic              halt_q, halt_d;
  logic              stall_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
      bubble_q <= 1'b0;
      halt_q   <= 1'b0;
    end else if (i_step_en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
      halt_q   <= halt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    bubble_d = bubble_q;
    halt_d   = halt_q;
    stall_pc = 1'b0;
    case (state_q)
      S_RUN: begin
        if (i_flush) begin
          ctrl_d   = '0;
          valid_d  = 1'b0;
          bubble_d = 1'b1;
        end else if (i_risk && i_valid) begin
          ctrl_d   = '0;
          valid_d  = 1'b0;
          bubble_d = 1'b1;
          cnt_d    = CNT_INIT;
          stall_pc = 1'b1;
          state_d  = (LOAD_USE_CYCLES > 1) ? S_STALL : S_RUN;
        end else begin
          ctrl_d   = i_ctrl;
          valid_d  = i_valid;
          bubble_d = 1'b0;
          // halt itself goes to EX so older instructions can drain
          if (i_valid && i_halt) begin
            state_d = S_HALTED;
            halt_d  = 1'b1;
          end
        end
      end
      S_STALL: begin
        stall_pc = 1'b1;
        ctrl_d   = '0;
        valid_d  = 1'b0;
        bubble_d = 1'b1;
        if (i_flush) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = S_RUN;
        end
      end
      S_HALTED: begin
        stall_pc = 1'b1;
        ctrl_d   = '0;
        valid_d  = 1'b0;
        bubble_d = 1'b0;
        halt_d   = 1'b1;
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_ctrl     = ctrl_q;
  assign o_valid    = valid_q;
  assign o_bubble   = bubble_q;
  assign o_halt     = halt_q;
  // state reads RUN during reset, so gate explicitly to keep PC free while reset is held
  assign o_stall_pc = i_rst_n & stall_pc;

`ifdef HAZARD_PERF_CNT_EN
  logic              risk_bubble;
  logic [PERF_W-1:0] perf_q;

  assign risk_bubble = ~i_flush & (((state_q == S_RUN) & i_risk & i_valid) | (state_q == S_STALL));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_q <= '0;
    end else if (i_step_en && risk_bubble && !(&perf_q)) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign o_perf_bubbles = perf_q;
`else
  assign o_perf_bubbles = '0;
`endif

endmodule
